// File: rtl/result_deskew_accumulator.sv
// Deskews per-row systolic array results into aligned vectors and overwrites or accumulates
// them into a flop-based buffer, with a one-cycle-latency read port for finished sums.
module result_deskew_accumulator #(
  parameter int unsigned MUL_SIZE  = 8,
  parameter int unsigned RES_WIDTH = 15,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned ACC_DEPTH = 64,
  parameter int unsigned ADDR_W    = $clog2(ACC_DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [MUL_SIZE-1:0][RES_WIDTH:0]    data_i,
  input  logic                                valid_i,
  input  logic                                stall_i,
  input  logic                                tile_start_i,
  input  logic [ADDR_W:0]                     num_vec_i,
  input  logic                                first_tile_i,
  input  logic                                last_tile_i,
  input  logic                                rd_en_i,
  input  logic [ADDR_W-1:0]                   rd_addr_i,
  output logic [MUL_SIZE-1:0][ACC_WIDTH-1:0]  rd_data_o,
  output logic                                rd_valid_o,
  output logic                                busy_o,
  output logic                                tile_done_o,
  output logic                                acc_ready_o,
  output logic                                err_o
);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                             state_q;
  logic [ADDR_W:0]                    num_vec_q, vld_cnt_q;
  logic [ADDR_W-1:0]                  wr_addr_q;
  logic                               first_q, last_q;
  logic [MUL_SIZE-2:0]                tok_q;
  logic [MUL_SIZE-1:0][RES_WIDTH:0]   aligned;
  logic [MUL_SIZE-1:0][ACC_WIDTH-1:0] acc_q [ACC_DEPTH];
  logic [MUL_SIZE-1:0][ACC_WIDTH-1:0] wr_data;
  logic                               tok_in, wr_en, last_wr, num_vec_ok;

  // Lane r arrives r cycles after lane 0, so it waits MUL_SIZE-1-r stages to line up.
  for (genvar r = 0; r < MUL_SIZE; r++) begin : g_lane
    localparam int Dly = int'(MUL_SIZE) - 1 - r;
    if (Dly == 0) begin : g_direct
      assign aligned[r] = data_i[r];
    end else begin : g_dly
      logic [RES_WIDTH:0] sr_q [Dly];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int k = 0; k < Dly; k++) sr_q[k] <= '0;
        end else if (!stall_i) begin
          sr_q[0] <= data_i[r];
          for (int k = 1; k < Dly; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign aligned[r] = sr_q[Dly-1];
    end
  end

  assign tok_in = valid_i && (state_q == StCollect);
  assign wr_en  = tok_q[MUL_SIZE-2] && !stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tok_q <= '0;
    end else if (!stall_i) begin
      tok_q <= (tok_q << 1) | (MUL_SIZE-1)'(tok_in);
    end
  end

  always_comb begin
    wr_data = '0;
    for (int l = 0; l < int'(MUL_SIZE); l++) begin
      wr_data[l] = first_q ? ACC_WIDTH'(aligned[l])
                           : acc_q[wr_addr_q][l] + ACC_WIDTH'(aligned[l]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < int'(ACC_DEPTH); e++) acc_q[e] <= '0;
    end else if (wr_en) begin
      acc_q[wr_addr_q] <= wr_data;
    end
  end

  assign last_wr    = wr_en && (((ADDR_W+1)'(wr_addr_q) + 1'b1) == num_vec_q);
  assign num_vec_ok = (num_vec_i != '0) && (num_vec_i <= (ADDR_W+1)'(ACC_DEPTH));
  assign busy_o     = (state_q != StIdle);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      num_vec_q   <= '0;
      vld_cnt_q   <= '0;
      wr_addr_q   <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      tile_done_o <= 1'b0;
      acc_ready_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      tile_done_o <= 1'b0;
      if (!stall_i) begin
        if (wr_en) wr_addr_q <= wr_addr_q + 1'b1;
        if (tile_start_i && state_q != StIdle) err_o <= 1'b1;
        if (valid_i && state_q != StCollect) err_o <= 1'b1;
        unique case (state_q)
          StIdle: begin
            if (tile_start_i) begin
              if (num_vec_ok) begin
                state_q   <= StCollect;
                num_vec_q <= num_vec_i;
                first_q   <= first_tile_i;
                last_q    <= last_tile_i;
                wr_addr_q <= '0;
                vld_cnt_q <= '0;
                if (first_tile_i) acc_ready_o <= 1'b0;
              end else begin
                err_o <= 1'b1;
              end
            end
          end
          StCollect: begin
            if (valid_i) begin
              vld_cnt_q <= vld_cnt_q + 1'b1;
              if ((vld_cnt_q + 1'b1) == num_vec_q) state_q <= StDrain;
            end
          end
          StDrain: begin
            if (last_wr) begin
              state_q     <= StIdle;
              tile_done_o <= 1'b1;
              if (last_q) acc_ready_o <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // The read port ignores stall; a same-cycle write is not forwarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= acc_q[rd_addr_i];
    end
  end

endmodule

// File: tb/tb_result_deskew_accumulator.sv
// Directed bench: skewed lane feeder, table of two-vector tiles, and hand-written corner cases.
module tb_result_deskew_accumulator;
  localparam int unsigned M   = 4;
  localparam int unsigned RW  = 7;
  localparam int unsigned AW  = 10;
  localparam int unsigned AD  = 8;
  localparam int unsigned ADW = 3;

  typedef logic [M-1:0][RW:0]   vec_t;
  typedef logic [M-1:0][AW-1:0] acc_t;
  typedef struct {
    logic first;
    logic last;
    vec_t d0;
    vec_t d1;
    acc_t e0;
    acc_t e1;
    logic ready;
  } row_t;

  logic         clk_i = 1'b0;
  logic         rst_i, valid_i, stall_i, tile_start_i, first_tile_i, last_tile_i, rd_en_i;
  vec_t         data_i;
  logic [ADW:0] num_vec_i;
  logic [ADW-1:0] rd_addr_i;
  acc_t         rd_data_o;
  logic         rd_valid_o, busy_o, tile_done_o, acc_ready_o, err_o;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t hist [M];
  vec_t tv [4];
  row_t tbl [5];

  result_deskew_accumulator #(
    .MUL_SIZE (M),
    .RES_WIDTH(RW),
    .ACC_WIDTH(AW),
    .ACC_DEPTH(AD),
    .ADDR_W   (ADW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .stall_i     (stall_i),
    .tile_start_i(tile_start_i),
    .num_vec_i   (num_vec_i),
    .first_tile_i(first_tile_i),
    .last_tile_i (last_tile_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .busy_o      (busy_o),
    .tile_done_o (tile_done_o),
    .acc_ready_o (acc_ready_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mv(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = (RW+1)'(a); v[1] = (RW+1)'(b); v[2] = (RW+1)'(c); v[3] = (RW+1)'(d);
    return v;
  endfunction

  function automatic acc_t ma(input int a, input int b, input int c, input int d);
    acc_t v;
    v[0] = AW'(a); v[1] = AW'(b); v[2] = AW'(c); v[3] = AW'(d);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Lane r carries lane r of the vector issued r unstalled cycles earlier.
  task automatic push(input logic v, input vec_t d);
    for (int k = M - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v ? d : '0;
    valid_i = v;
    stall_i = 1'b0;
    for (int r = 0; r < M; r++) data_i[r] = hist[r][r];
    tick();
  endtask

  task automatic stall_cyc();
    stall_i = 1'b1;
    valid_i = 1'b1;
    data_i  = {M{8'hAA}};
    tick();
    stall_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tile_start_i = 1'b0; rd_en_i = 1'b0;
    for (int k = 0; k < M; k++) hist[k] = '0;
    push(1'b0, '0);
    push(1'b0, '0);
    rst_i = 1'b0;
  endtask

  task automatic start(input logic first, input logic last, input int n);
    tile_start_i = 1'b1;
    num_vec_i    = (ADW+1)'(n);
    first_tile_i = first;
    last_tile_i  = last;
    push(1'b0, '0);
    tile_start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cnt);
    int cnt = 0;
    while (!tile_done_o && cnt < 12) begin
      push(1'b0, '0);
      cnt++;
    end
    chk({nm, "_done_lat"}, cnt, exp_cnt);
  endtask

  task automatic read_chk(input string nm, input int addr, input acc_t exp);
    rd_en_i   = 1'b1;
    rd_addr_i = ADW'(addr);
    push(1'b0, '0);
    rd_en_i = 1'b0;
    chk({nm, "_rvalid"}, rd_valid_o, 1);
    chk(nm, rd_data_o, exp);
  endtask

  task automatic run_tile(input string nm, input logic first, input logic last, input int n);
    start(first, last, n);
    chk({nm, "_busy"}, busy_o, 1);
    for (int i = 0; i < n; i++) push(1'b1, tv[i]);
    wait_done(nm, M - 1);
    push(1'b0, '0);
    chk({nm, "_done_pulse"}, tile_done_o, 0);
    chk({nm, "_idle"}, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    tbl[0] = '{first: 1'b1, last: 1'b1, d0: mv(1, 2, 3, 4), d1: mv(5, 6, 7, 8),
               e0: ma(1, 2, 3, 4), e1: ma(5, 6, 7, 8), ready: 1'b1};
    tbl[1] = '{first: 1'b1, last: 1'b0, d0: mv(1, 2, 3, 4), d1: mv(5, 6, 7, 8),
               e0: ma(1, 2, 3, 4), e1: ma(5, 6, 7, 8), ready: 1'b0};
    tbl[2] = '{first: 1'b0, last: 1'b1, d0: mv(1, 2, 3, 4), d1: mv(5, 6, 7, 8),
               e0: ma(2, 4, 6, 8), e1: ma(10, 12, 14, 16), ready: 1'b1};
    tbl[3] = '{first: 1'b1, last: 1'b1, d0: mv(255, 128, 0, 17), d1: mv(200, 1, 2, 3),
               e0: ma(255, 128, 0, 17), e1: ma(200, 1, 2, 3), ready: 1'b1};
    tbl[4] = '{first: 1'b0, last: 1'b0, d0: mv(255, 255, 255, 255), d1: mv(1, 1, 1, 1),
               e0: ma(510, 383, 255, 272), e1: ma(201, 2, 3, 4), ready: 1'b1};

    valid_i = 1'b0; stall_i = 1'b0; tile_start_i = 1'b0; first_tile_i = 1'b0;
    last_tile_i = 1'b0; rd_en_i = 1'b0; rd_addr_i = '0; num_vec_i = '0; data_i = '0;
    do_reset();
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", acc_ready_o, 0);
    chk("rst_done", tile_done_o, 0);
    chk("rst_rvalid", rd_valid_o, 0);
    chk("rst_rdata", rd_data_o, 0);
    read_chk("rst_entry0", 0, '0);
    push(1'b0, '0);
    chk("rvalid_drop", rd_valid_o, 0);

    for (int i = 0; i < 5; i++) begin
      tv[0] = tbl[i].d0;
      tv[1] = tbl[i].d1;
      run_tile($sformatf("row%0d", i), tbl[i].first, tbl[i].last, 2);
      read_chk($sformatf("row%0d_e0", i), 0, tbl[i].e0);
      read_chk($sformatf("row%0d_e1", i), 1, tbl[i].e1);
      chk($sformatf("row%0d_ready", i), acc_ready_o, tbl[i].ready);
    end

    // Drive entry 0 to all-ones, then add 1 so it wraps to zero.
    tv[0] = mv(255, 255, 255, 255);
    run_tile("wrap_a", 1'b1, 1'b0, 1);
    for (int i = 0; i < 3; i++) run_tile("wrap_b", 1'b0, 1'b0, 1);
    tv[0] = mv(3, 3, 3, 3);
    run_tile("wrap_c", 1'b0, 1'b0, 1);
    read_chk("wrap_max", 0, ma(1023, 1023, 1023, 1023));
    tv[0] = mv(1, 1, 1, 1);
    run_tile("wrap_d", 1'b0, 1'b1, 1);
    read_chk("wrap_zero", 0, '0);
    chk("wrap_err", err_o, 0);

    // Stall inside the skew window; the read port keeps working throughout.
    start(1'b1, 1'b1, 1);
    push(1'b1, mv(9, 10, 11, 12));
    push(1'b0, '0);
    rd_en_i = 1'b1; rd_addr_i = 3'd1;
    stall_cyc();
    rd_en_i = 1'b0;
    chk("stall_rd_valid", rd_valid_o, 1);
    chk("stall_rd_data", rd_data_o, ma(201, 2, 3, 4));
    stall_cyc();
    stall_cyc();
    chk("stall_no_early", tile_done_o, 0);
    wait_done("stall", 2);
    stall_cyc();
    chk("stall_done_not_ext", tile_done_o, 0);
    read_chk("stall_e0", 0, ma(9, 10, 11, 12));
    chk("stall_err", err_o, 0);

    do_reset();
    tv[0] = mv(9, 10, 11, 12);
    run_tile("e1", 1'b1, 1'b1, 1);
    push(1'b1, mv(77, 77, 77, 77));
    chk("e1_err", err_o, 1);
    chk("e1_busy", busy_o, 0);
    for (int i = 0; i < 4; i++) push(1'b0, '0);
    chk("e1_err_sticky", err_o, 1);
    read_chk("e1_e0", 0, ma(9, 10, 11, 12));
    read_chk("e1_e1", 1, '0);

    for (int i = 0; i < 2; i++) begin
      do_reset();
      chk("e2_err_clr", err_o, 0);
      start(1'b1, 1'b1, (i == 0) ? 0 : 9);
      chk($sformatf("e2_err_%0d", i), err_o, 1);
      chk($sformatf("e2_busy_%0d", i), busy_o, 0);
      push(1'b0, '0);
      chk($sformatf("e2_sticky_%0d", i), err_o, 1);
    end

    do_reset();
    start(1'b1, 1'b1, 2);
    push(1'b1, mv(21, 22, 23, 24));
    tile_start_i = 1'b1; num_vec_i = 4'd1;
    push(1'b1, mv(31, 32, 33, 34));
    tile_start_i = 1'b0;
    chk("e3_err", err_o, 1);
    chk("e3_busy", busy_o, 1);
    wait_done("e3", M - 1);
    read_chk("e3_e0", 0, ma(21, 22, 23, 24));
    read_chk("e3_e1", 1, ma(31, 32, 33, 34));

    // Reset while draining abandons the tile.
    do_reset();
    start(1'b1, 1'b1, 2);
    push(1'b1, mv(41, 42, 43, 44));
    push(1'b1, mv(51, 52, 53, 54));
    push(1'b0, '0);
    rst_i = 1'b1;
    push(1'b0, '0);
    rst_i = 1'b0;
    chk("rd_busy", busy_o, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, '0);
      if (tile_done_o) seen++;
    end
    chk("rd_no_done", seen, 0);
    read_chk("rd_e0", 0, '0);
    read_chk("rd_e1", 1, '0);

    // Read entry 3 in the same cycle it is written.
    start(1'b1, 1'b1, 4);
    push(1'b1, mv(1, 1, 1, 1));
    push(1'b1, mv(2, 2, 2, 2));
    push(1'b1, mv(3, 3, 3, 3));
    push(1'b1, mv(60, 61, 62, 63));
    push(1'b0, '0);
    push(1'b0, '0);
    rd_en_i = 1'b1; rd_addr_i = 3'd3;
    push(1'b0, '0);
    rd_en_i = 1'b0;
    chk("col_rvalid", rd_valid_o, 1);
    chk("col_old", rd_data_o, '0);
    chk("col_done", tile_done_o, 1);
    read_chk("col_new", 3, ma(60, 61, 62, 63));
    read_chk("col_e2", 2, ma(3, 3, 3, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
